// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by uart_rx, uart_tx and uart_tx_arbiter.
//   arb_state_t : arbiter FSM states
//   num_words() : number of UART words packed into one transfer of w_out bits
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      SEND,
      GAP
   } arb_state_t;

   function automatic int unsigned num_words(input int unsigned w_out,
                                             input int unsigned bits_per_word);
      return w_out / bits_per_word;
   endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational winner selection for uart_tx_arbiter.
// Default: round robin, search starts at (ptr + 1) mod N_REQ so the last-served requester
// has the lowest priority. With UART_ARB_FIXED_PRIO_EN defined, the lowest index with req set
// always wins and ptr is ignored.
// Ports:
//   req    in   N_REQ          request vector
//   ptr    in   $clog2(N_REQ)  index of last-served requester
//   winner out  $clog2(N_REQ)  selected index (0 when no request)
//   any    out  1              at least one request present
module uart_rr_picker
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             any
);

`ifdef UART_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      any    = |req;
      winner = '0;
      // Walk downwards so the lowest set index is written last.
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req[i]) winner = IW'(i);
      end
   end
`else
   always_comb begin
      logic        found;
      int unsigned idx;
      any    = |req;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            winner = IW'(idx);
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ requesters. One winner is granted, its word is
// latched and presented downstream, then GAP_CLOCKS idle cycles are enforced.
// FSM: IDLE -> GRANT -> SEND -> (GAP) -> IDLE.
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority (in uart_rr_picker).
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   s_valid    per-requester word valid
//   s_data     per-requester word (uart_tx s_data packing)
//   s_ready    one-cycle accept pulse to the granted requester
//   m_valid    word valid to uart_tx
//   m_data     latched word to uart_tx
//   m_ready    uart_tx ready
//   grant_id   index of current/last winner
//   busy       high whenever the FSM is not IDLE
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned BITS_PER_WORD = 8,
   parameter int unsigned W_OUT         = 16,
   parameter int unsigned GAP_CLOCKS    = 0,
   localparam int unsigned IW = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [N_REQ-1:0]            s_valid,
   input  logic [N_REQ-1:0][W_OUT-1:0] s_data,
   output logic [N_REQ-1:0]            s_ready,
   output logic                        m_valid,
   output logic [W_OUT-1:0]            m_data,
   input  logic                        m_ready,
   output logic [IW-1:0]               grant_id,
   output logic                        busy
);

   localparam int unsigned NumWords = num_words(W_OUT, BITS_PER_WORD);
   localparam int unsigned GW       = (GAP_CLOCKS > 1) ? $clog2(GAP_CLOCKS) : 1;
   localparam int unsigned GapLast  = (GAP_CLOCKS > 0) ? GAP_CLOCKS - 1 : 0;

   if (N_REQ < 2) begin : g_bad_nreq
      $error("uart_tx_arbiter: N_REQ must be at least 2");
   end
   if (NumWords * BITS_PER_WORD != W_OUT) begin : g_bad_width
      $error("uart_tx_arbiter: W_OUT must be a multiple of BITS_PER_WORD");
   end

   arb_state_t    state_q;
   logic [IW-1:0] rr_ptr_q;
   logic [GW-1:0] gap_cnt_q;
   logic [IW-1:0] pick_id;
   logic          pick_any;

   uart_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req    (s_valid),
      .ptr    (rr_ptr_q),
      .winner (pick_id),
      .any    (pick_any)
   );

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         s_ready   <= '0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         grant_id  <= '0;
         // Pointing at the last requester makes requester 0 the first winner.
         rr_ptr_q  <= IW'(N_REQ - 1);
         gap_cnt_q <= '0;
      end else begin
         s_ready <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_id;
                  s_ready  <= N_REQ'(1) << pick_id;
                  state_q  <= GRANT;
               end
            end
            GRANT: begin
               // A requester that dropped s_valid here forfeits its turn; pointer untouched.
               if (s_valid[grant_id]) begin
                  m_data  <= s_data[grant_id];
                  m_valid <= 1'b1;
                  state_q <= SEND;
               end else begin
                  state_q <= IDLE;
               end
            end
            SEND: begin
               if (m_ready) begin
                  m_valid  <= 1'b0;
                  rr_ptr_q <= grant_id;
                  if (GAP_CLOCKS > 0) begin
                     gap_cnt_q <= '0;
                     state_q   <= GAP;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == GW'(GapLast)) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (N_REQ=4, W_OUT=16, GAP_CLOCKS=3).
// Expected (grant_id, word) pairs are queued when requests are loaded; a negedge monitor pops
// and compares on every downstream handshake. Build with UART_ARB_FIXED_PRIO_EN for the
// fixed-priority variant; expected orders switch accordingly.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int GAPC = 3;

   logic                clk = 1'b0;
   logic                rstn;
   logic [N-1:0]        s_valid;
   logic [N-1:0][W-1:0] s_data;
   logic [N-1:0]        s_ready;
   logic                m_valid;
   logic [W-1:0]        m_data;
   logic                m_ready;
   logic [1:0]          grant_id;
   logic                busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ         (N),
      .BITS_PER_WORD (8),
      .W_OUT         (W),
      .GAP_CLOCKS    (GAPC)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .grant_id (grant_id),
      .busy     (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   // Per-requester word lists; the driver owns rd, the stimulus owns wr.
   logic [W-1:0] wq  [N][16];
   bit           wdq [N][16];
   int           wr  [N];
   int           rd  [N];
   logic [N-1:0] acc;

   int         cyc = 0;
   int         hs_cnt = 0;
   int         grant_cnt = 0;
   int         last_hs_cyc = 0;
   int         last_grant_cyc = 0;
   logic [1:0] last_grant_id = '0;

   // Requester driver: holds valid/data until accepted, optionally withdraws when granted.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (!rstn) rd[i] = wr[i];
         else if (acc[i]) rd[i]++;
         else if (rd[i] < wr[i] && wdq[i][rd[i]] && s_ready[i]) rd[i]++;
         s_valid[i] = (rd[i] < wr[i]);
         s_data[i]  = (rd[i] < wr[i]) ? wq[i][rd[i]] : '0;
      end
   end

   // Monitor: counts grants/handshakes and checks every handshake against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      acc = s_valid & s_ready;
      if (!rstn) begin
         sb.delete();
      end else begin
         if (s_ready != '0) begin
            grant_cnt++;
            last_grant_cyc = cyc;
            last_grant_id  = grant_id;
            check("ready_onehot", 32'(s_ready), 32'(1) << grant_id);
         end
         if (m_valid && m_ready) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_handshake: got id=%0d data=%h, want none", grant_id,
                        m_data);
            end else begin
               e = sb.pop_front();
               check("hs_grant_id", 32'(grant_id), 32'(e.id));
               check("hs_data", 32'(m_data), 32'(e.data));
            end
         end
      end
   end

   task automatic load(input int i, input logic [W-1:0] d, input bit wd);
      wq[i][wr[i]]  = d;
      wdq[i][wr[i]] = wd;
      wr[i]++;
   endtask

   task automatic expect_word(input int i, input logic [W-1:0] d);
      exp_t e;
      e.id   = 2'(i);
      e.data = d;
      sb.push_back(e);
   endtask

   function automatic bit pending();
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (rd[i] < wr[i]) pending = 1'b1;
   endfunction

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || pending() || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < 1000), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_mvalid(input string name);
      int n = 0;
      while (!m_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(m_valid), 32'd1);
   endtask

   task automatic wait_hs(input int target, input string name);
      int n = 0;
      while (hs_cnt < target && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(hs_cnt >= target), 32'd1);
   endtask

   task automatic wait_grant(input int target, input string name);
      int n = 0;
      while (grant_cnt < target && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(grant_cnt >= target), 32'd1);
   endtask

   initial begin
      int hb, gb, h1;
      bit ok;
      rstn    = 1'b0;
      m_ready = 1'b1;
      #2;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Single request: s_ready at t+1, m_valid at t+2.
      @(negedge clk);
      load(2, 16'hA55A, 1'b0);
      expect_word(2, 16'hA55A);
      @(negedge clk);
      check("single_idle_ready", 32'(s_ready), 32'd0);
      check("single_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("single_ready_t1", 32'(s_ready), 32'h4);
      check("single_grant_id", 32'(grant_id), 32'd2);
      check("single_no_mvalid_t1", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("single_mvalid_t2", 32'(m_valid), 32'd1);
      check("single_mdata_t2", 32'(m_data), 32'hA55A);
      check("single_ready_gone", 32'(s_ready), 32'd0);
      drain("single_drain");
      check("single_busy_low", 32'(busy), 32'd0);

      // Reset while SEND is stalled drops the word and clears outputs at once.
      m_ready = 1'b0;
      load(1, 16'h1111, 1'b0);
      wait_mvalid("rstmid_reach_send");
      check("rstmid_pre_grant", 32'(grant_id), 32'd1);
      check("rstmid_pre_data", 32'(m_data), 32'h1111);
      #1 rstn = 1'b0;
      #1;
      check("rstmid_m_valid", 32'(m_valid), 32'd0);
      check("rstmid_m_data", 32'(m_data), 32'd0);
      check("rstmid_grant_id", 32'(grant_id), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rstn    = 1'b1;
      m_ready = 1'b1;

      // All four requesting, req0 re-asserts after accept.
      @(negedge clk);
      load(0, 16'h0A00, 1'b0);
      load(0, 16'h0A10, 1'b0);
      load(1, 16'h1B01, 1'b0);
      load(2, 16'h2C02, 1'b0);
      load(3, 16'h3D03, 1'b0);
`ifdef UART_ARB_FIXED_PRIO_EN
      expect_word(0, 16'h0A00);
      expect_word(0, 16'h0A10);
      expect_word(1, 16'h1B01);
      expect_word(2, 16'h2C02);
      expect_word(3, 16'h3D03);
`else
      expect_word(0, 16'h0A00);
      expect_word(1, 16'h1B01);
      expect_word(2, 16'h2C02);
      expect_word(3, 16'h3D03);
      expect_word(0, 16'h0A10);
`endif
      drain("rr_drain");

      // Backpressure: 50 stalled cycles with another requester waiting.
      m_ready = 1'b0;
      hb = hs_cnt;
      load(3, 16'h3C3C, 1'b0);
      expect_word(3, 16'h3C3C);
      wait_mvalid("bp_reach_send");
      load(1, 16'h1E1E, 1'b0);
      expect_word(1, 16'h1E1E);
      ok = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!m_valid || m_data !== 16'h3C3C || s_ready !== '0) ok = 1'b0;
      end
      check("bp_hold_stable", 32'(ok), 32'd1);
      check("bp_no_handshake", 32'(hs_cnt - hb), 32'd0);
      m_ready = 1'b1;
      drain("bp_drain");
      check("bp_handshakes", 32'(hs_cnt - hb), 32'd2);

      // Back-to-back requests: handshake cycle, GAPC gap cycles, one IDLE cycle, then GRANT.
      hb = hs_cnt;
      gb = grant_cnt;
      load(0, 16'h0E00, 1'b0);
      load(2, 16'h2E02, 1'b0);
`ifdef UART_ARB_FIXED_PRIO_EN
      expect_word(0, 16'h0E00);
      expect_word(2, 16'h2E02);
`else
      expect_word(2, 16'h2E02);
      expect_word(0, 16'h0E00);
`endif
      wait_hs(hb + 1, "gap_first_hs");
      h1 = last_hs_cyc;
      wait_grant(gb + 2, "gap_second_grant");
      check("gap_spacing", 32'(last_grant_cyc - h1), 32'(GAPC + 2));
      drain("gap_drain");

      // Withdrawal during GRANT: no transfer, pointer unchanged.
      hb = hs_cnt;
      gb = grant_cnt;
      load(3, 16'h3F3F, 1'b1);
      wait_grant(gb + 1, "wd_grant_seen");
      check("wd_grant_id", 32'(last_grant_id), 32'd3);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (m_valid) ok = 1'b0;
      end
      check("wd_no_mvalid", 32'(ok), 32'd1);
      check("wd_no_handshake", 32'(hs_cnt - hb), 32'd0);
      check("wd_idle", 32'(busy), 32'd0);
      // Last served was req0, so req1 must beat req0 under round robin.
      load(0, 16'h0F00, 1'b0);
      load(1, 16'h1F01, 1'b0);
`ifdef UART_ARB_FIXED_PRIO_EN
      expect_word(0, 16'h0F00);
      expect_word(1, 16'h1F01);
`else
      expect_word(1, 16'h1F01);
      expect_word(0, 16'h0F00);
`endif
      drain("wd_follow_drain");

`ifdef UART_ARB_FIXED_PRIO_EN
      // req0 kept busy starves req3 until req0 runs dry.
      load(0, 16'h0100, 1'b0);
      load(0, 16'h0101, 1'b0);
      load(0, 16'h0102, 1'b0);
      load(3, 16'h3300, 1'b0);
      expect_word(0, 16'h0100);
      expect_word(0, 16'h0101);
      expect_word(0, 16'h0102);
      expect_word(3, 16'h3300);
      drain("fixed_drain");
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
